match_reporter: RTL and testbench
=================================

# match_reporter

Downstream stage of the pattern search accelerator. It accepts match addresses from the search engine and buffers them in a FIFO. It transmits each address over a UART TX line as two uppercase ASCII hex characters followed by CR LF. When the search finishes it sends a `D` CR LF completion frame, so a host terminal can read results without stalling the search.

## Interface
- `CLK_HZ`, 100_000_000, clock frequency in Hz.
- `BAUD`, 115200, UART bit rate.
- `ADDR_W`, 8, match address width.
- `FIFO_DEPTH`, 16, match FIFO entries (power of two).

- `CLK100MHZ`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `match_valid`  in  1  search engine presents a match this cycle.
- `match_addr`  in  ADDR_W  BRAM address where the pattern starts.
- `match_ready`  out  1  high when FIFO not full.
- `search_done`  in  1  one-cycle pulse at end of search.
- `tx`  out  1  UART 8N1 serial output, idle high.
- `busy`  out  1  frame in progress, FIFO non-empty, or done pending.
- `overflow`  out  1  sticky; a match was dropped.
- `match_count`  out  8  accepted matches, saturating at 255.

## Operation
- Accept: `match_valid && match_ready` writes `match_addr` to the FIFO and increments `match_count`. `match_count` saturates at 255.
- Drop: `match_valid && !match_ready` discards the address and sets `overflow`. `overflow` stays set until `reset`. The engine never stalls.
- Done latch: `search_done` sets `done_pending`. Repeated pulses while pending merge into one completion frame.
- FSM states: IDLE, POP, SEND_HI, SEND_LO, SEND_CR, SEND_LF, SEND_D.
  - IDLE → POP when the FIFO is non-empty.
  - IDLE → SEND_D when the FIFO is empty and `done_pending`.
  - POP registers the FIFO head and moves to SEND_HI.
  - SEND_HI → SEND_LO → SEND_CR → SEND_LF → IDLE. Each state issues one character and advances when the UART reports completion.
  - SEND_D sends `D` (0x44), then passes through SEND_CR and SEND_LF, clears `done_pending`, and returns to IDLE.
- Hex encoding: a nibble 0–9 maps to 0x30–0x39; a nibble A–F maps to 0x41–0x46. The high nibble is sent first.
- Ordering: a match accepted in the same cycle as `search_done` is reported before `D`. Matches accepted after `done_pending` is set are still reported before `D`. `D` is sent only once the FIFO is empty at an IDLE decision.
- UART framing:
  - Character: start bit 0, 8 data bits LSB first, stop bit 1.
  - Bit period `CLKS_PER_BIT` = `CLK_HZ/BAUD`, integer-truncated (868 at defaults).
- Reset values:
  - `tx`=1, `match_ready`=1, `busy`=0, `overflow`=0, `match_count`=0.
  - FIFO empty, FSM in IDLE, `done_pending`=0.

## Timing
- Latency: match accepted at edge N into an empty FIFO with the FSM in IDLE.
  - POP registers the byte at edge N+1.
  - `tx` falls for the start bit at edge N+2.
- Character duration is exactly 10×`CLKS_PER_BIT` cycles. The next start bit follows the previous stop bit with no idle gap.
- A match frame is 4 characters (34720 cycles at defaults).
- FIFO occupancy:
  - Write and pop in the same cycle leaves occupancy unchanged.
  - `match_ready` is registered from occupancy: it goes low the cycle after the FIFO becomes full.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- Reset mid-frame:
  - `tx` is high at the edge following `reset`; the partial character is abandoned.
  - FIFO contents and `done_pending` are discarded.

## Structure
- Shared package `psa_pkg`:
  - ASCII constants `ASCII_CR`, `ASCII_LF`, `ASCII_D`.
  - FSM state enum `rep_state_t`.
  - Function `hex_ascii(nibble)`.
- Sub-module `uart_tx`:
  - Parameter `CLKS_PER_BIT`.
  - Ports `CLK100MHZ`, `reset`, `start`, `data[7:0]`, `tx`, `busy`, `done` (one-cycle pulse at end of stop bit).
  - Used for all character output.
- FIFO is inline: register array plus read/write pointers with an extra wrap bit.

## Test plan
- Single match 0x3A while idle → `tx` start bit 2 cycles after acceptance. Bytes 0x33, 0x41, 0x0D, 0x0A, each bit 868 cycles. `match_count`=1, `busy` falls after LF stop bit.
- `search_done` pulse with empty FIFO → bytes 0x44, 0x0D, 0x0A; `busy` then low.
- `match_valid` held 20 consecutive cycles with addresses 0x00–0x13 → first 17 accepted, 3 dropped. `overflow`=1, `match_count`=17, and 17 frames `00`…`10` in order.
- `match_valid` with 0xFF and `search_done` in the same cycle → frame `FF` CR LF, then `D` CR LF.
- `reset` asserted mid-character of the second of 3 queued matches → `tx`=1 next edge. No further output, `busy`=0, `match_count`=0, `overflow`=0.
- 300 spaced matches with the FIFO never full → `match_count` saturates at 255, `overflow` stays 0.

Source files
------------

// File: rtl/psa_pkg.sv
// psa_pkg: shared ASCII constants, reporter FSM states and hex encoding
package psa_pkg;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_D  = 8'h44;
  typedef enum logic [2:0] {IDLE, POP, SEND_HI, SEND_LO, SEND_CR, SEND_LF, SEND_D} rep_state_t;
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    return nibble < 4'd10 ? 8'h30 + {4'h0, nibble} : 8'h37 + {4'h0, nibble};
  endfunction
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serializer that can take the next byte in the last stop-bit cycle
module uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] cnt;
  logic [3:0] bits;
  logic [8:0] sh;
  assign done = busy && cnt == LAST && bits == 4'd9;
  // shift out start, data LSB first and stop; chain the next byte without a gap
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      tx <= 1'b1;
      busy <= 1'b0;
      cnt <= '0;
      bits <= '0;
      sh <= '1;
    end else if (start && (!busy || done)) begin
      tx <= 1'b0;
      busy <= 1'b1;
      cnt <= '0;
      bits <= '0;
      sh <= {1'b1, data};
    end else if (busy) begin
      cnt <= cnt == LAST ? '0 : cnt + CW'(1);
      if (cnt == LAST) begin
        tx <= sh[0];
        sh <= {1'b1, sh[8:1]};
        bits <= bits + 4'd1;
        busy <= bits != 4'd9;
      end
    end
  end
endmodule

// File: rtl/match_reporter.sv
// match_reporter: buffers match addresses and reports them as hex text over UART
module match_reporter #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              match_valid,
  input  logic [ADDR_W-1:0] match_addr,
  output logic              match_ready,
  input  logic              search_done,
  output logic              tx,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        match_count
);
  import psa_pkg::*;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  logic [ADDR_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] cur;
  logic [AW:0] wr, rd, occ_n;
  logic [7:0] ch;
  logic empty, wr_en, pop, start, u_done, u_busy, d_frame, done_pending;
  rep_state_t state, nxt;
  assign empty = wr == rd;
  assign wr_en = match_valid && match_ready;
  assign occ_n = wr - rd + PW'(wr_en) - PW'(pop);
  assign busy = state != IDLE || !empty || done_pending || u_busy;
  // FIFO storage, registered ready flag and match statistics
  always_ff @(posedge CLK100MHZ) begin
    if (wr_en) mem[wr[AW-1:0]] <= match_addr;
    if (reset) begin
      wr <= '0;
      rd <= '0;
      match_ready <= 1'b1;
      overflow <= 1'b0;
      match_count <= '0;
    end else begin
      wr <= wr + PW'(wr_en);
      rd <= rd + PW'(pop);
      match_ready <= occ_n != PW'(FIFO_DEPTH);
      overflow <= overflow | (match_valid & ~match_ready);
      match_count <= match_count + 8'(wr_en && match_count != 8'hFF);
    end
  end
  // state register, latched FIFO head and completion-frame bookkeeping
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state <= IDLE;
      cur <= '0;
      d_frame <= 1'b0;
      done_pending <= 1'b0;
    end else begin
      state <= nxt;
      if (pop) cur <= mem[rd[AW-1:0]];
      d_frame <= nxt == SEND_D || (d_frame && nxt != IDLE);
      done_pending <= search_done || (done_pending && !(d_frame && state == SEND_LF && u_done));
    end
  end
  // next state and character issue; each send state launches its successor's character
  always_comb begin
    nxt = state;
    start = 1'b0;
    ch = ASCII_CR;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        start = empty && done_pending;
        ch = ASCII_D;
        nxt = !empty ? POP : done_pending ? SEND_D : IDLE;
      end
      POP: begin
        nxt = SEND_HI;
        start = 1'b1;
        ch = hex_ascii(cur[7:4]);
      end
      SEND_HI: begin
        nxt = u_done ? SEND_LO : SEND_HI;
        start = u_done;
        ch = hex_ascii(cur[3:0]);
      end
      SEND_LO, SEND_D: begin
        nxt = u_done ? SEND_CR : state;
        start = u_done;
      end
      SEND_CR: begin
        nxt = u_done ? SEND_LF : SEND_CR;
        start = u_done;
        ch = ASCII_LF;
      end
      SEND_LF: nxt = u_done ? IDLE : SEND_LF;
      default: nxt = IDLE;
    endcase
  end
  uart_tx #(.CLKS_PER_BIT(CLK_HZ / BAUD)) u_tx (
    .CLK100MHZ(CLK100MHZ),
    .reset(reset),
    .start(start),
    .data(ch),
    .tx(tx),
    .busy(u_busy),
    .done(u_done)
  );
endmodule

// File: tb/tb_match_reporter.sv
// tb_match_reporter: scoreboard bench decoding the UART line against queued expected bytes
module tb_match_reporter;
  localparam int CPB = 4;
  logic clk = 1'b0, reset = 1'b1, match_valid = 1'b0, search_done = 1'b0;
  logic [7:0] match_addr = '0;
  logic match_ready, tx, busy, overflow;
  logic [7:0] match_count;
  int checks = 0, errors = 0;
  logic [7:0] q[$];

  match_reporter #(.CLK_HZ(100_000_000), .BAUD(24_000_000), .ADDR_W(8), .FIFO_DEPTH(16)) dut (
    .CLK100MHZ(clk), .reset(reset), .match_valid(match_valid), .match_addr(match_addr),
    .match_ready(match_ready), .search_done(search_done), .tx(tx), .busy(busy),
    .overflow(overflow), .match_count(match_count));

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    string s = "0123456789ABCDEF";
    return s[n];
  endfunction

  task automatic push_match(input logic [7:0] a);
    q.push_back(hx(a[7:4]));
    q.push_back(hx(a[3:0]));
    q.push_back(8'h0D);
    q.push_back(8'h0A);
  endtask

  task automatic push_done();
    q.push_back(8'h44);
    q.push_back(8'h0D);
    q.push_back(8'h0A);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_match(input logic [7:0] a);
    tick(1);
    match_valid = 1'b1;
    match_addr = a;
    tick(1);
    match_valid = 1'b0;
  endtask

  task automatic do_reset();
    tick(1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((busy || q.size() != 0) && k < budget) begin
      tick(1);
      k++;
    end
    chk(name, 32'(k >= budget), 32'd0);
  endtask

  // monitor: decode each character by sampling mid-bit, compare against the scoreboard
  initial begin
    bit on = 1'b0;
    int cnt = 0;
    logic [7:0] sh = '0;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (reset) on = 1'b0;
      else if (!on) begin
        if (!tx) begin
          on = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt % CPB == CPB / 2) begin
          if (cnt / CPB >= 1 && cnt / CPB <= 8) sh[cnt / CPB - 1] = tx;
          if (cnt / CPB == 9) begin
            on = 1'b0;
            chk("stop_bit", 32'(tx), 32'd1);
            if (q.size() == 0) chk("unexpected_byte", 32'(sh), 32'hFFFF_FFFF);
            else begin
              exp = q.pop_front();
              chk("tx_byte", 32'(sh), 32'(exp));
            end
          end
        end
      end
    end
  end

  initial begin
    int k;
    do_reset();
    chk("rst_tx", 32'(tx), 1);
    chk("rst_ready", 32'(match_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_count", 32'(match_count), 0);

    push_match(8'h3A);
    drive_match(8'h3A);
    chk("lat_n", 32'(tx), 1);
    tick(1);
    chk("lat_n1", 32'(tx), 1);
    tick(1);
    chk("lat_n2_start", 32'(tx), 0);
    k = 0;
    while (busy && k < 1000) begin
      tick(1);
      k++;
    end
    chk("frame_cycles", 32'(k), 32'(40 * CPB));
    tick(2);
    chk("t1_queue", 32'(q.size()), 0);
    chk("t1_count", 32'(match_count), 1);

    push_done();
    tick(1);
    search_done = 1'b1;
    tick(1);
    search_done = 1'b0;
    tick(5);
    search_done = 1'b1;
    tick(1);
    search_done = 1'b0;
    wait_idle("t2_idle", 2000);
    tick(20);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_queue", 32'(q.size()), 0);

    do_reset();
    for (int i = 0; i < 17; i++) push_match(8'(i));
    tick(1);
    match_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      match_addr = 8'(i);
      tick(1);
    end
    match_valid = 1'b0;
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_count", 32'(match_count), 17);
    chk("t3_ready_full", 32'(match_ready), 0);
    wait_idle("t3_idle", 17 * 200);
    chk("t3_ready_after", 32'(match_ready), 1);
    chk("t3_overflow_sticky", 32'(overflow), 1);

    do_reset();
    push_match(8'hFF);
    push_match(8'h5C);
    push_done();
    tick(1);
    match_valid = 1'b1;
    match_addr = 8'hFF;
    search_done = 1'b1;
    tick(1);
    match_valid = 1'b0;
    search_done = 1'b0;
    tick(10);
    drive_match(8'h5C);
    wait_idle("t4_idle", 3000);
    chk("t4_count", 32'(match_count), 2);

    do_reset();
    push_match(8'h11);
    push_match(8'h22);
    push_match(8'h33);
    drive_match(8'h11);
    drive_match(8'h22);
    drive_match(8'h33);
    tick(40 * CPB + 3 + 4 * CPB + 2);
    chk("t5_mid_char", 32'(busy), 1);
    reset = 1'b1;
    q.delete();
    tick(1);
    chk("t5_tx_after_reset", 32'(tx), 1);
    reset = 1'b0;
    tick(400);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_count", 32'(match_count), 0);
    chk("t5_overflow", 32'(overflow), 0);
    chk("t5_tx_idle", 32'(tx), 1);

    do_reset();
    for (int b = 0; b < 25; b++) begin
      for (int j = 0; j < 12; j++) begin
        push_match(8'(b * 12 + j));
        drive_match(8'(b * 12 + j));
      end
      wait_idle("t6_idle", 12 * 200);
      if (b == 20) chk("t6_count_252", 32'(match_count), 252);
    end
    chk("t6_count_sat", 32'(match_count), 255);
    chk("t6_overflow", 32'(overflow), 0);
    chk("final_queue", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
